datapath_arbiter: RTL and testbench

DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

---
 rtl/datapath_arbiter.sv | 80 ++++++++
 tb/tb_datapath_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin arbiter sharing one fixed-latency datapath among several requesters
module datapath_arbiter #(
    parameter int WIDTH         = 8,
    parameter int NR_REQUESTERS = 4,
    parameter int DP_LATENCY    = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NR_REQUESTERS-1:0]       req_valid_i,
    input  logic [NR_REQUESTERS*WIDTH-1:0] req_data_i,
    output logic [NR_REQUESTERS-1:0]       req_ready_o,
    output logic [WIDTH-1:0]               dp_data_o,
    input  logic [WIDTH-1:0]               dp_data_i,
    output logic [NR_REQUESTERS-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]               rsp_data_o,
    output logic                           busy_o
);
    localparam int IW = $clog2(NR_REQUESTERS);
    localparam int CW = $clog2(DP_LATENCY + 1);
    localparam logic [NR_REQUESTERS-1:0] ONE = NR_REQUESTERS'(1);

    if (WIDTH == 0 || NR_REQUESTERS < 2 || DP_LATENCY == 0) begin : g_bad_params
        $error("datapath_arbiter: illegal parameters");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, g_q, g, ix;
    logic [CW-1:0] cnt;
    logic          hit;

    // first requesting index at or above rr_ptr, wrapping; lower offsets win by being assigned last
    always_comb begin
        g   = '0;
        hit = 1'b0;
        ix  = '0;
        for (int i = NR_REQUESTERS - 1; i >= 0; i--) begin
            ix = IW'((int'(rr_ptr) + i) % NR_REQUESTERS);
            if (req_valid_i[ix]) begin
                g   = ix;
                hit = 1'b1;
            end
        end
    end

    // next state and decoded outputs; reset forces state to IDLE so only ready needs gating
    always_comb begin
        state_nx    = (state == IDLE) ? (hit ? WAIT : IDLE) :
                      (state == WAIT) ? ((cnt == CW'(1)) ? RESPOND : WAIT) : IDLE;
        req_ready_o = (state == IDLE && hit && !rst_i) ? ONE << g : '0;
        rsp_valid_o = (state == RESPOND) ? ONE << g_q : '0;
        busy_o      = (state != IDLE);
    end

    // state, grant capture, latency countdown and data registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g_q        <= '0;
            cnt        <= '0;
            dp_data_o  <= '0;
            rsp_data_o <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && hit) begin
                dp_data_o <= req_data_i[g*WIDTH +: WIDTH];
                g_q       <= g;
                cnt       <= CW'(DP_LATENCY);
            end else begin
                cnt <= (cnt == '0) ? '0 : cnt - CW'(1);
            end
            if (state == WAIT && cnt == CW'(1))
                rsp_data_o <= dp_data_i;
            if (state == RESPOND)
                rr_ptr <= (g_q == IW'(NR_REQUESTERS - 1)) ? '0 : g_q + IW'(1);
        end
    end
endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: directed checks of grant order, latency, reset and ignored requests
module tb_datapath_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rv, rr, rsv;
    logic [31:0] rd;
    logic [7:0]  dpo, dpi, rsd;
    logic        busy;
    logic [3:0]  rv3, rr3, rsv3;
    logic [31:0] rd3;
    logic [7:0]  dpo3, dpi3, rsd3;
    logic        busy3;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dpi = dpo;

    datapath_arbiter #(.WIDTH(8), .NR_REQUESTERS(4), .DP_LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_data_i(rd), .req_ready_o(rr),
        .dp_data_o(dpo), .dp_data_i(dpi), .rsp_valid_o(rsv), .rsp_data_o(rsd), .busy_o(busy));

    datapath_arbiter #(.WIDTH(8), .NR_REQUESTERS(4), .DP_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rv3), .req_data_i(rd3), .req_ready_o(rr3),
        .dp_data_o(dpo3), .dp_data_i(dpi3), .rsp_valid_o(rsv3), .rsp_data_o(rsd3), .busy_o(busy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rv = 0; rd = 0; rv3 = 0; rd3 = 0; dpi3 = 0;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_dpo", {24'd0, dpo}, 0);
        chk("rst_rsd", {24'd0, rsd}, 0);
        step; step;
        rst = 1'b0;
        step;
        // single request to requester 2
        rv = 4'b0100; rd = 32'h005A_0000;
        #1;
        chk("single_ready", {28'd0, rr}, 4'b0100);
        chk("single_busy_T", {31'd0, busy}, 0);
        step;
        rv = 0;
        chk("single_dpo", {24'd0, dpo}, 8'h5A);
        chk("single_busy_T1", {31'd0, busy}, 1);
        chk("single_rsv_T1", {28'd0, rsv}, 0);
        step;
        chk("single_rsv", {28'd0, rsv}, 4'b0100);
        chk("single_rsd", {24'd0, rsd}, 8'h5A);
        chk("single_busy_T2", {31'd0, busy}, 1);
        step;
        chk("single_idle", {31'd0, busy}, 0);
        chk("single_rsv_off", {28'd0, rsv}, 0);
        chk("single_rsd_hold", {24'd0, rsd}, 8'h5A);
        chk("single_dpo_hold", {24'd0, dpo}, 8'h5A);
        // wrap and skip from rr_ptr=3 with requesters 0 and 1 pending
        rv = 4'b0011; rd = 32'h0000_2211;
        #1;
        chk("wrap_grant0", {28'd0, rr}, 4'b0001);
        step;
        rv = 4'b0010;
        chk("wrap_wait_ready", {28'd0, rr}, 0);
        step;
        chk("wrap_rsv0", {28'd0, rsv}, 4'b0001);
        chk("wrap_rsd0", {24'd0, rsd}, 8'h11);
        step;
        chk("wrap_grant1", {28'd0, rr}, 4'b0010);
        step;
        // requester 3 appears and vanishes while busy
        rv = 4'b1000;
        #1;
        chk("ign_ready_wait", {28'd0, rr}, 0);
        step;
        rv = 0;
        chk("ign_ready_rsp", {28'd0, rr}, 0);
        chk("wrap_rsv1", {28'd0, rsv}, 4'b0010);
        chk("wrap_rsd1", {24'd0, rsd}, 8'h22);
        step;
        chk("ign_never_ready", {28'd0, rr}, 0);
        chk("ign_idle", {31'd0, busy}, 0);
        step;
        chk("ign_still_idle", {31'd0, busy}, 0);
        // reset pulsed during WAIT of a grant to requester 2
        rv = 4'b0100; rd = 32'h0077_0000;
        #1;
        chk("rstmid_ready", {28'd0, rr}, 4'b0100);
        step;
        rv = 0;
        chk("rstmid_busy_before", {31'd0, busy}, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 0);
        chk("rstmid_dpo", {24'd0, dpo}, 0);
        chk("rstmid_rsd", {24'd0, rsd}, 0);
        chk("rstmid_rsv", {28'd0, rsv}, 0);
        #1 rst = 1'b0;
        step;
        chk("rstmid_no_rsp", {28'd0, rsv}, 0);
        // all requesters held: 0,1,2,3,0 every three cycles, starting right after reset
        rv = 4'b1111; rd = 32'hA3A2_A1A0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", {28'd0, rr}, 32'(1 << (k % 4)));
            step;
            chk("rr_dpo", {24'd0, dpo}, 32'(8'hA0 + (k % 4)));
            chk("rr_ready_busy", {28'd0, rr}, 0);
            step;
            chk("rr_rsv", {28'd0, rsv}, 32'(1 << (k % 4)));
            chk("rr_rsd", {24'd0, rsd}, 32'(8'hA0 + (k % 4)));
            step;
        end
        rv = 0;
        step;
        // latency 3: datapath output changes every WAIT cycle, the last one must be captured
        rv3 = 4'b0010; rd3 = 32'h0000_3C00;
        #1;
        chk("lat_ready", {28'd0, rr3}, 4'b0010);
        step;
        rv3 = 0;
        dpi3 = 8'h10;
        chk("lat_dpo", {24'd0, dpo3}, 8'h3C);
        chk("lat_rsv_T1", {28'd0, rsv3}, 0);
        step;
        dpi3 = 8'h20;
        chk("lat_rsv_T2", {28'd0, rsv3}, 0);
        chk("lat_busy_T2", {31'd0, busy3}, 1);
        step;
        dpi3 = 8'h30;
        chk("lat_rsv_T3", {28'd0, rsv3}, 0);
        step;
        dpi3 = 8'h40;
        chk("lat_rsv_T4", {28'd0, rsv3}, 4'b0010);
        chk("lat_rsd", {24'd0, rsd3}, 8'h30);
        step;
        chk("lat_idle", {31'd0, busy3}, 0);
        chk("lat_rsd_hold", {24'd0, rsd3}, 8'h30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
